// File: rtl/dcache_responder_if.sv
// Cachebus between memory_stage (master) and the data cache (slave).
// Handshake: the master holds addr/read/write/wdata stable while stall_o is
// high; a request completes at the first rising clk edge where stall_o is low.
interface dcache_responder_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr_i;
    logic              read_i;
    logic              write_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              stall_o;

    modport master (
        output addr_i, read_i, write_i, wdata_i,
        input  rdata_o, stall_o
    );

    modport slave (
        input  addr_i, read_i, write_i, wdata_i,
        output rdata_o, stall_o
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read hits return data combinationally; misses fill a whole line over the
// word-wide backing-memory port, and every write goes straight to memory.
// Backing-memory handshake: mem_req_o/we/addr/wdata are registered and held
// stable until the cycle mem_ack_i is high; each ack moves one word.
module dcache_responder #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_responder_if.slave    bus,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [31:0]          mem_rdata_i,
    output logic [1:0]           dbg_state
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]       state_q;
    logic [OFF_W-1:0] fill_cnt_q;
    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS*LINE_WORDS];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             fill_last;
    logic [OFF_W-1:0] fill_next;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] fill_next_addr;
    logic [ADDR_W-1:0] word_addr;
    logic             unused_addr_bits;

    assign req_off = bus.addr_i[2 +: OFF_W];
    assign req_idx = bus.addr_i[2+OFF_W +: IDX_W];
    assign req_tag = bus.addr_i[ADDR_W-1 -: TAG_W];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Byte-lane bits are ignored: the bus is word access only.
    assign unused_addr_bits = ^bus.addr_i[1:0];

    assign fill_last      = &fill_cnt_q;
    assign fill_next      = fill_cnt_q + 1'b1;
    assign line_base      = {bus.addr_i[ADDR_W-1:2+OFF_W], {(OFF_W+2){1'b0}}};
    assign fill_next_addr = {bus.addr_i[ADDR_W-1:2+OFF_W], fill_next, 2'b00};
    assign word_addr      = {bus.addr_i[ADDR_W-1:2], 2'b00};

    assign dbg_state = state_q;

    // Cachebus response: hit data and the pipeline stall.
    always_comb begin
        bus.rdata_o = 32'h0;
        bus.stall_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.read_i && hit) begin
                    bus.rdata_o = data_q[{req_idx, req_off}];
                end
                bus.stall_o = bus.write_i || (bus.read_i && !hit);
            end
            S_FILL:  bus.stall_o = 1'b1;
            // Release the pipeline exactly in the ack cycle so the write
            // is not presented twice.
            S_WRITE: bus.stall_o = !mem_ack_i;
            default: bus.stall_o = 1'b0;
        endcase
    end

    // Control FSM, valid bits and the registered backing-memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fill_cnt_q  <= '0;
            valid_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.write_i) begin
                        state_q     <= S_WRITE;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= word_addr;
                        mem_wdata_o <= bus.wdata_i;
                    end else if (bus.read_i && !hit) begin
                        state_q    <= S_FILL;
                        fill_cnt_q <= '0;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= line_base;
                    end
                end
                S_FILL: begin
                    if (mem_ack_i) begin
                        fill_cnt_q <= fill_next;
                        if (fill_last) begin
                            valid_q[req_idx] <= 1'b1;
                            state_q          <= S_IDLE;
                            mem_req_o        <= 1'b0;
                        end else begin
                            mem_addr_o <= fill_next_addr;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack_i) begin
                        state_q   <= S_IDLE;
                        mem_req_o <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Data and tag storage; only a completed fill makes a line usable, so
    // words landed by a fill that reset abandons stay invisible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_FILL && mem_ack_i) begin
                data_q[{req_idx, fill_cnt_q}] <= mem_rdata_i;
                if (fill_last) begin
                    tag_q[req_idx] <= req_tag;
                end
            end else if (state_q == S_WRITE && mem_ack_i && hit) begin
                data_q[{req_idx, req_off}] <= bus.wdata_i;
            end
        end
    end

endmodule
